// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/half/word accesses, two-cycle ERROR response and
// optional wait states (enabled by defining AHB_SLV_WAIT_EN).
module ahb_sram_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                MEM_BYTES   = 4096,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata
);

  localparam int                MEM_WORDS = MEM_BYTES / 4;
  localparam int                IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            r_state;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]        r_wait_cnt;
`endif

  logic [31:0]       r_mem [MEM_WORDS];

  logic              w_accept;
  logic [ADDR_W-1:0] w_off;
  logic              w_misalign;
  logic              w_err;
  logic [ADDR_W-1:0] w_roff;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_lane;
  logic              w_we;
  logic              w_unused;

  assign w_accept   = hsel & hready & htrans[1];
  // An address below BASE_ADDR wraps to a huge offset and fails the range test.
  assign w_off      = haddr - BASE_ADDR;
  assign w_misalign = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err      = (w_off >= MEM_LIMIT) || (hsize > 3'd2) || w_misalign;

  assign w_roff = r_addr - BASE_ADDR;
  assign w_idx  = w_roff[IDX_W+1:2];
  assign w_we   = (r_state == S_DATA) && r_write;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_lane = 4'b0000;
    case (r_size[1:0])
      2'd0:    w_lane = 4'b0001 << r_addr[1:0];
      2'd1:    w_lane = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_lane = 4'b1111;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
`ifdef AHB_SLV_WAIT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
          if (r_wait_cnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_wait_cnt  <= r_wait_cnt - 4'd1;
          end
`else
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
`endif
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with hready high, so a new accept can land here.
          if (w_accept) begin
            r_addr  <= haddr;
            r_write <= hwrite;
            r_size  <= hsize;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
`ifdef AHB_SLV_WAIT_EN
            end else if (WAIT_CYCLES != 0) begin
              r_state     <= S_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_wait_cnt  <= 4'(WAIT_CYCLES - 1);
`endif
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: the array has no reset; SRAM contents survive hreset_n by design.
  always_ff @(posedge hclk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane[b]) r_mem[w_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = ((r_state == S_DATA) && !r_write) ? r_mem[w_idx] : 32'h0;

  assign w_unused = ^{hburst, htrans[0], r_size[2], w_roff, 4'(WAIT_CYCLES)};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave; expected wait count follows
// whether AHB_SLV_WAIT_EN is defined for the build.
module tb_ahb_sram_slave;

`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign hready = hreadyout;

  ahb_sram_slave #(
    .ADDR_W(32), .MEM_BYTES(4096), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata)
  );

  // One non-pipelined transfer; reports wait cycles and what was seen in them.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, output int waits, output logic resp_w,
                      output logic resp_l, output logic [31:0] rd_w, output logic [31:0] rd_l);
    logic done;
    waits = 0; resp_w = 1'b0; resp_l = 1'b0; rd_w = '0; rd_l = '0; done = 1'b0;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge hclk);
      if (hreadyout) begin
        resp_l = hresp; rd_l = hrdata; done = 1'b1;
      end else begin
        waits++; resp_w = resp_w | hresp; rd_w = rd_w | hrdata;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL xfer_timeout: addr %h hreadyout stuck at %b, want 1", addr, hreadyout);
    end
    @(posedge hclk); #1;
    hwdata = '0;
  endtask

  task automatic test_reset();
    hreset_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hwdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    n_vec++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", hreadyout); end
    n_vec++; if (hresp !== 1'b0) begin n_err++; $display("FAIL rst_resp: got %b want 0", hresp); end
    n_vec++; if (hrdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", hrdata); end
    hreset_n = 1'b1;
  endtask

  task automatic test_word_rw();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, w, rw, rl, dw, dl);
    n_vec++; if (w !== EXP_WAIT) begin n_err++; $display("FAIL wr_waits: got %0d want %0d", w, EXP_WAIT); end
    n_vec++; if (dl !== 32'h0) begin n_err++; $display("FAIL wr_rdata_zero: got %h want 0", dl); end
    xfer(32'h10, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (w !== EXP_WAIT) begin n_err++; $display("FAIL rd_waits: got %0d want %0d", w, EXP_WAIT); end
    n_vec++; if (dl !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", dl); end
    n_vec++; if (rl !== 1'b0 || rw !== 1'b0) begin n_err++; $display("FAIL rd_resp: got %b/%b want 0/0", rw, rl); end
  endtask

  task automatic test_sub_word();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h10, 1'b1, 3'd2, 32'h0, w, rw, rl, dw, dl);
    xfer(32'h13, 1'b1, 3'd0, 32'h5A00_0000, w, rw, rl, dw, dl);
    xfer(32'h10, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'h5A00_0000) begin n_err++; $display("FAIL byte_lane3: got %h want 5a000000", dl); end
    xfer(32'h14, 1'b1, 3'd2, 32'h0, w, rw, rl, dw, dl);
    xfer(32'h16, 1'b1, 3'd1, 32'hCAFE_1111, w, rw, rl, dw, dl);
    xfer(32'h14, 1'b1, 3'd0, 32'h7777_77AB, w, rw, rl, dw, dl);
    xfer(32'h14, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'hCAFE_00AB) begin n_err++; $display("FAIL half_byte_lanes: got %h want cafe00ab", dl); end
    xfer(32'h15, 1'b1, 3'd0, 32'h0000_3C00, w, rw, rl, dw, dl);
    xfer(32'h14, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'hCAFE_3CAB) begin n_err++; $display("FAIL byte_lane1: got %h want cafe3cab", dl); end
  endtask

  task automatic test_wait();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h20, 1'b1, 3'd2, 32'h1122_3344, w, rw, rl, dw, dl);
    xfer(32'h20, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (w !== EXP_WAIT) begin n_err++; $display("FAIL wait_count: got %0d want %0d", w, EXP_WAIT); end
    n_vec++; if (rw !== 1'b0 || rl !== 1'b0) begin n_err++; $display("FAIL wait_resp: got %b/%b want 0/0", rw, rl); end
    n_vec++; if (dw !== 32'h0) begin n_err++; $display("FAIL wait_rdata_zero: got %h want 0", dw); end
    n_vec++; if (dl !== 32'h1122_3344) begin n_err++; $display("FAIL wait_data: got %h want 11223344", dl); end
  endtask

  task automatic test_error();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h0, 1'b1, 3'd2, 32'h0102_0304, w, rw, rl, dw, dl);
    xfer(32'h1000, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (w !== 1 || rw !== 1'b1) begin n_err++; $display("FAIL err1_phase: got waits %0d resp %b want 1/1", w, rw); end
    n_vec++; if (rl !== 1'b1) begin n_err++; $display("FAIL err2_resp: got %b want 1", rl); end
    n_vec++; if (dw !== 32'h0 || dl !== 32'h0) begin n_err++; $display("FAIL err_rdata: got %h/%h want 0/0", dw, dl); end
    xfer(32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF, w, rw, rl, dw, dl);
    xfer(32'h0, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'h0102_0304) begin n_err++; $display("FAIL err_no_wrap: got %h want 01020304", dl); end
    xfer(32'h24, 1'b0, 3'd3, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (w !== 1 || rl !== 1'b1) begin n_err++; $display("FAIL err_hsize: got waits %0d resp %b want 1/1", w, rl); end
    xfer(32'hFFC, 1'b1, 3'd2, 32'h600D_CAFE, w, rw, rl, dw, dl);
    xfer(32'hFFC, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'h600D_CAFE || rl !== 1'b0) begin n_err++; $display("FAIL last_word: got %h resp %b want 600dcafe/0", dl, rl); end
  endtask

  task automatic test_misaligned();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h21, 1'b1, 3'd1, 32'hFFFF_FFFF, w, rw, rl, dw, dl);
    n_vec++; if (w !== 1 || rw !== 1'b1 || rl !== 1'b1) begin n_err++; $display("FAIL mis_half_err: got waits %0d resp %b/%b want 1 1/1", w, rw, rl); end
    xfer(32'h22, 1'b1, 3'd2, 32'hFFFF_FFFF, w, rw, rl, dw, dl);
    n_vec++; if (w !== 1 || rl !== 1'b1) begin n_err++; $display("FAIL mis_word_err: got waits %0d resp %b want 1/1", w, rl); end
    xfer(32'h20, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'h1122_3344) begin n_err++; $display("FAIL mis_no_write: got %h want 11223344", dl); end
  endtask

  task automatic test_unselected();
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b01;
    @(negedge hclk);
    n_vec++; if (hrdata !== 32'h0 || hreadyout !== 1'b1) begin n_err++; $display("FAIL unsel_no_access: got %h/%b want 0/1", hrdata, hreadyout); end
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    n_vec++; if (hrdata !== 32'h0 || hresp !== 1'b0) begin n_err++; $display("FAIL busy_no_access: got %h/%b want 0/0", hrdata, hresp); end
  endtask

  task automatic test_back_to_back();
    int w; logic rw, rl; logic [31:0] dw, dl; int w1, w2; logic done;
    xfer(32'h40, 1'b1, 3'd2, 32'h1234_5678, w, rw, rl, dw, dl);
    w1 = 0; w2 = 0; dl = '0;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    haddr = 32'h40; hwrite = 1'b0; hwdata = 32'h0BAD_F00D;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge hclk);
      if (hreadyout) done = 1'b1; else w1++;
    end
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = '0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge hclk);
      if (hreadyout) begin done = 1'b1; dl = hrdata; end else w2++;
    end
    n_vec++; if (w1 !== EXP_WAIT || w2 !== EXP_WAIT) begin n_err++; $display("FAIL b2b_waits: got %0d/%0d want %0d", w1, w2, EXP_WAIT); end
    n_vec++; if (dl !== 32'h0BAD_F00D) begin n_err++; $display("FAIL b2b_raw: got %h want 0badf00d", dl); end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset_abort();
    int w; logic rw, rl; logic [31:0] dw, dl;
    xfer(32'h30, 1'b1, 3'd2, 32'hA5A5_A5A5, w, rw, rl, dw, dl);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    n_vec++; if (hreadyout !== (EXP_WAIT == 0)) begin n_err++; $display("FAIL abort_pre_state: got %b want %b", hreadyout, EXP_WAIT == 0); end
    #2 hreset_n = 1'b0;
    #1;
    n_vec++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_err++; $display("FAIL abort_outputs: got %b/%b want 1/0", hreadyout, hresp); end
    @(negedge hclk); @(negedge hclk);
    hreset_n = 1'b1; hwdata = '0;
    xfer(32'h30, 1'b0, 3'd2, 32'h0, w, rw, rl, dw, dl);
    n_vec++; if (dl !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL abort_no_commit: got %h want a5a5a5a5", dl); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_sub_word();
    test_wait();
    test_error();
    test_misaligned();
    test_unselected();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave memory model that sits directly downstream of the AHB interconnect DUT and terminates one slave port.
- Stores word-addressed SRAM contents and accepts byte, halfword and word accesses.
- Drives hreadyout/hresp/hrdata back to the interconnect, with optional wait-state insertion and a two-cycle ERROR response.
- One instance is placed per slave interface in the bus test environment.

Parameters:
- ADDR_W, 32, width of haddr.
- MEM_BYTES, 4096, memory size in bytes; power of two, at least 4.
- WAIT_CYCLES, 2, wait states inserted per NONSEQ/SEQ transfer, range 0..15; used only when AHB_SLV_WAIT_EN is defined.
- BASE_ADDR, 32'h0, byte address that maps to memory offset 0.

Ports:
- hclk  in  1  bus clock; all state on the rising edge.
- hreset_n  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the interconnect decoder.
- haddr  in  ADDR_W  address-phase address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  0=byte, 1=half, 2=word; values above 2 are illegal.
- hburst  in  3  burst type; informational only, no behaviour depends on it.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-wide ready; qualifies address-phase sampling.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset (async, hreset_n=0):
  - FSM returns to IDLE.
  - hreadyout=1, hresp=0, hrdata=0.
  - All address-phase registers clear.
  - Memory contents are NOT reset.
  - Reset asserted mid-transfer aborts it; no write is committed.
- Address-phase accept: on a rising edge with hsel & hready & htrans[1]. Latch haddr, hwrite and hsize into addr_q/wr_q/size_q.
- IDLE/BUSY or hsel=0 with hready=1: no access; the next data phase returns OKAY with zero wait.
- Error check at accept. The transfer is an error if any of:
  - (haddr-BASE_ADDR) >= MEM_BYTES;
  - hsize > 2;
  - misaligned (hsize=1 and haddr[0]=1, or hsize=2 and haddr[1:0]!=0).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT if the wait count is nonzero, else DATA. On an error accept, go to ERR1.
  - WAIT: hreadyout=0, hresp=0. The counter loads WAIT_CYCLES-1 at accept and decrements each cycle; at 0, go to DATA.
  - DATA: hreadyout=1, hresp=0.
    - Write: commit hwdata byte lanes to the memory word at this edge. Lane mask comes from size_q/addr_q[1:0] (byte lane = addr_q[1:0]; half lanes {1,0} or {3,2}; word = all).
    - Read: hrdata = full memory word at addr_q, driven combinationally during DATA.
    - If a new accept occurs at the same edge, re-enter WAIT/DATA/ERR1 directly (back-to-back pipelining). Otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write. An accept at this edge is handled as from IDLE.
- hrdata is 0 outside read DATA cycles, including during errors and writes.
- Read-after-write to the same word in consecutive transfers returns the new data: the write commits at the DATA edge, before the read's DATA cycle.
- Zero-wait latency: a read accepted at edge N has hrdata valid in the cycle after N, with hreadyout=1.
- Memory index = (addr_q-BASE_ADDR)[log2(MEM_BYTES)-1:2]. Addresses never wrap; out-of-range addresses are errors.

Optional Feature:
- AHB_SLV_WAIT_EN defined: WAIT state is used with WAIT_CYCLES wait states per transfer.
- AHB_SLV_WAIT_EN undefined: WAIT state and counter are removed and WAIT_CYCLES is ignored. Every legal transfer has zero wait; the error response is unchanged.

Test Plan:
- Write word 32'hDEADBEEF to 0x10, then read 0x10 (zero wait, undefined macro) -> hrdata=32'hDEADBEEF in the cycle after the read accept, hreadyout=1, hresp=0.
- Byte write 8'h5A to 0x13 over word 0x00000000, then word read 0x10 -> hrdata=32'h5A000000.
- Macro defined, WAIT_CYCLES=2, read 0x20 -> hreadyout=0 for exactly 2 cycles, then 1 with data; hresp=0 throughout.
- Read 0x1000 with MEM_BYTES=4096 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); hrdata=0; memory unchanged.
- Halfword write to 0x21 (misaligned) -> two-cycle ERROR; a following read of 0x20 returns its prior contents.
- Assert hreset_n=0 during WAIT of a write to 0x30 -> hreadyout=1 and hresp=0 immediately; a later read of 0x30 returns the pre-write value.
